mem_bus_arbiter: RTL and testbench

- Shares the single 16-bit memory port (program/data/stack RAM) between three CPU-side requesters: 0 = instruction fetch, 1 = data load/store, 2 = stack push/pop and I/O.
- Sequences each access through a fixed wait-state memory and returns a registered ack and read data to the winning requester.
- Sits between the CPU core FSM and the memory array.

---
 rtl/mem_bus_arbiter_if.sv | 38 +++
 rtl/mem_bus_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Purpose: bundles the three-requester CPU side and the single memory port of mem_bus_arbiter.
// Latency: none; this is a plain signal bundle.
// Backpressure: requesters hold req until they see their ack bit; there is no other stall path.
//
// Port summary (all widths fixed except the addresses):
//   req/we        [2:0]           per-requester request and write enable
//   addr          [3*ADDR_W-1:0]  requester i at [i*ADDR_W +: ADDR_W]
//   wdata         [47:0]          requester i at [i*16 +: 16]
//   gnt/ack       [2:0]           one-hot bus ownership / one-cycle completion pulse
//   rdata         [15:0]          read data, valid while ack is high
//   mem_*                         single memory port (en, we, addr, wdata out; rdata in)
// Modports: slave = the arbiter's view, master = the CPU core plus memory array around it.
interface mem_bus_arbiter_if #(
  parameter int unsigned ADDR_W = 16
) ();
  logic [2:0]          req;
  logic [2:0]          we;
  logic [3*ADDR_W-1:0] addr;
  logic [47:0]         wdata;
  logic [2:0]          gnt;
  logic [2:0]          ack;
  logic [15:0]         rdata;
  logic                mem_en;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [15:0]         mem_wdata;
  logic [15:0]         mem_rdata;

  modport slave (
    input  req, we, addr, wdata, mem_rdata,
    output gnt, ack, rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req, we, addr, wdata, mem_rdata,
    input  gnt, ack, rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Purpose: shares one 16-bit wait-state memory port between fetch (0), data (1) and stack/IO (2).
// Latency: req sampled at edge E0 -> ack in cycle WAIT_STATES+1; one access per WAIT_STATES+2 cycles.
// Backpressure: a requester is stalled simply by not being granted; it holds req until its ack.
//
// Ports: clk (rising edge), rst_n (async, active low), bus (mem_bus_arbiter_if.slave).
// Parameters: WAIT_STATES (0..15, extra memory cycles per access), ADDR_W (address width).
// Build option: define MEM_BUS_ARBITER_FIXED_PRIO_EN for fixed priority 0 > 1 > 2; otherwise
// round-robin starting after the last owner. Timing and handshake are the same in both modes.
// All outputs come straight from flops.
module mem_bus_arbiter #(
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned ADDR_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_bus_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  // Everything the memory port needs for one access, latched from the winner at grant time.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       wdata;
  } mem_cmd_t;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_STATES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  owner_q, owner_d;
  logic [1:0]  rr_ptr_q, rr_ptr_d;
  logic [2:0]  gnt_q, gnt_d;
  logic [2:0]  ack_q, ack_d;
  logic [15:0] rdata_q, rdata_d;
  logic        mem_en_q, mem_en_d;
  mem_cmd_t    cmd_q, cmd_d;

  logic [2:0]  arb_req;
  logic [1:0]  win;
  mem_cmd_t    win_cmd;

  // Requests visible to the arbiter. In RESP the requester being acked has not yet had a
  // chance to drop req, so its bit is masked to avoid re-granting it a stale request.
  always_comb begin
    arb_req = 3'b000;
    case (state_q)
      IDLE:    arb_req = bus.req;
      RESP:    arb_req = bus.req & ~gnt_q;
      default: arb_req = 3'b000;
    endcase
  end

`ifdef MEM_BUS_ARBITER_FIXED_PRIO_EN
  // Fixed priority 0 > 1 > 2. rr_ptr is still tracked but has no effect here.
  always_comb begin
    win = 2'd2;
    if (arb_req[1]) win = 2'd1;
    if (arb_req[0]) win = 2'd0;
  end
`else
  // Round-robin: search starts at the requester after the last owner, wrapping mod 3.
  logic [1:0] rr_first, rr_second, rr_third;

  always_comb begin
    rr_first  = (rr_ptr_q >= 2'd2) ? 2'd0 : rr_ptr_q + 2'd1;
    rr_second = (rr_first == 2'd2) ? 2'd0 : rr_first + 2'd1;
    rr_third  = (rr_second == 2'd2) ? 2'd0 : rr_second + 2'd1;
    // Later assignments override earlier ones, so rr_first has the highest priority.
    win = rr_third;
    if (arb_req[rr_second]) win = rr_second;
    if (arb_req[rr_first])  win = rr_first;
  end
`endif

  always_comb begin
    win_cmd.we    = bus.we[win];
    win_cmd.addr  = bus.addr[int'(win)*ADDR_W +: ADDR_W];
    win_cmd.wdata = bus.wdata[int'(win)*16 +: 16];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    gnt_d    = gnt_q;
    ack_d    = 3'b000;
    rdata_d  = rdata_q;
    mem_en_d = mem_en_q;
    cmd_d    = cmd_q;

    case (state_q)
      // IDLE and RESP arbitrate identically; only the request mask above differs.
      // Granting straight out of RESP gives back-to-back accesses with no idle cycle.
      IDLE, RESP: begin
        if (|arb_req) begin
          state_d  = ACCESS;
          owner_d  = win;
          gnt_d    = 3'b001 << win;
          mem_en_d = 1'b1;
          cmd_d    = win_cmd;
          cnt_d    = 4'd0;
        end else begin
          state_d  = IDLE;
          gnt_d    = 3'b000;
          mem_en_d = 1'b0;
          cmd_d.we = 1'b0;
        end
      end

      // Memory strobes stay frozen for WAIT_STATES+1 cycles; mem_rdata is taken on the
      // closing edge. Address and write data keep their values after the access ends.
      ACCESS: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_CNT) begin
          if (!cmd_q.we) begin
            rdata_d = bus.mem_rdata;
          end
          ack_d    = gnt_q;
          mem_en_d = 1'b0;
          cmd_d.we = 1'b0;
          rr_ptr_d = owner_q;
          state_d  = RESP;
        end
      end

      default: begin
        state_d  = IDLE;
        gnt_d    = 3'b000;
        mem_en_d = 1'b0;
        cmd_d.we = 1'b0;
      end
    endcase
  end

  // Reset abandons any in-flight access without an ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      owner_q  <= 2'd0;
      rr_ptr_q <= 2'd2;
      gnt_q    <= 3'b000;
      ack_q    <= 3'b000;
      rdata_q  <= 16'h0000;
      mem_en_q <= 1'b0;
      cmd_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
      mem_en_q <= mem_en_d;
      cmd_q    <= cmd_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.ack       = ack_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = cmd_q.we;
  assign bus.mem_addr  = cmd_q.addr;
  assign bus.mem_wdata = cmd_q.wdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Purpose: randomized scoreboard bench for mem_bus_arbiter with a transaction-level model.
// Latency: model expects ack WS+1 cycles after each grant edge.
// Backpressure: requesters hold req until they see their ack, then drop it for at least a cycle.
module tb_mem_bus_arbiter;
  localparam int WS = 1;
  localparam int AW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.ADDR_W(AW)) bus ();

  mem_bus_arbiter #(.WAIT_STATES(WS), .ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Arbitration rule taken from the specification: round-robin after the last owner,
  // or strict 0 > 1 > 2 when the fixed-priority build is selected.
  function automatic int pick(input logic [2:0] pend, input int last);
`ifdef MEM_BUS_ARBITER_FIXED_PRIO_EN
    for (int i = 0; i < 3; i++) if (pend[i]) return i;
`else
    for (int k = 1; k <= 3; k++) if (pend[(last + k) % 3]) return (last + k) % 3;
`endif
    return -1;
  endfunction

  // ---------------- requester driver state ----------------
  logic [2:0]  busy;
  logic [2:0]  last_ack;
  logic        r_we [3];
  logic [15:0] r_addr [3];
  logic [15:0] r_wdata [3];
  bit          reraise, rand_en, drop_en;

  function automatic logic [15:0] rand_addr();
    logic [31:0] r;
    r = $urandom;
    // Small set of low-byte values so reads often hit earlier writes.
    return {r[15:8], 5'b00000, r[2:0]};
  endfunction

  task automatic raise(input int i, input logic we, input logic [15:0] a, input logic [15:0] d);
    r_we[i] = we;
    r_addr[i] = a;
    r_wdata[i] = d;
    busy[i] = 1'b1;
    bus.req[i] = 1'b1;
    bus.we[i] = we;
    bus.addr[i*AW +: AW] = a;
    bus.wdata[i*16 +: 16] = d;
  endtask

  task automatic drive();
    logic [2:0] seen;
    seen = last_ack;
    last_ack = bus.ack;
    for (int i = 0; i < 3; i++) begin
      if (seen[i]) begin
        busy[i] = 1'b0;
        bus.req[i] = 1'b0;
      end else if (busy[i]) begin
        if (drop_en && bus.gnt[i] && bus.req[i] && $urandom_range(7) == 0) bus.req[i] = 1'b0;
      end else if (reraise || (rand_en && $urandom_range(2) == 0)) begin
        raise(i, 1'($urandom_range(1)), rand_addr(), 16'($urandom));
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive();
  endtask

  // ---------------- monitor / scoreboard / memory device ----------------
  typedef struct {
    int          id;
    int          due;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } exp_t;

  exp_t        sb [$];
  int          ack_own_q [$];
  int          ack_cyc_q [$];
  logic [15:0] mem_arr [256];
  logic [15:0] ref_mem [256];

  initial begin
    int          cyc, last_own, dev_run, w;
    logic [2:0]  prev_req, prev_ack, prev_gnt, pend;
    bit          prev_mem_en, prev_ok, free;
    logic [15:0] model_rdata, exp_rd, run_addr, run_wdata;
    logic        run_we;
    exp_t        e;

    for (int i = 0; i < 256; i++) begin
      mem_arr[i] = 16'(i * 257) ^ 16'h5A5A;
      ref_mem[i] = 16'(i * 257) ^ 16'h5A5A;
    end
    mem_arr[8'h40] = 16'hBEEF;
    ref_mem[8'h40] = 16'hBEEF;
    bus.mem_rdata = 16'h0000;
    cyc = 0; last_own = 2; dev_run = 0; prev_ok = 0; prev_mem_en = 0;
    prev_req = '0; prev_ack = '0; prev_gnt = '0; model_rdata = '0;
    run_addr = '0; run_wdata = '0; run_we = 1'b0;

    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
        last_own = 2; model_rdata = '0; prev_ok = 0; dev_run = 0; prev_mem_en = 0;
        bus.mem_rdata = 16'($urandom);
      end else begin
        cyc++;
        check("gnt_onehot", 32'($countones(bus.gnt) <= 1), 1);
        check("ack_onehot", 32'($countones(bus.ack) <= 1), 1);
        check("ack_single_cycle", 32'(bus.ack & prev_ack), 0);
        if (bus.mem_en) begin
          check("mem_en_no_ack", 32'(bus.ack), 0);
          check("mem_en_has_gnt", 32'(bus.gnt != 0), 1);
        end

        // Bus is free to arbitrate when idle (no gnt) or in the ack cycle.
        if (prev_ok) begin
          pend = prev_req & ~prev_ack;
          free = (prev_gnt == 3'b000) || (prev_ack != 3'b000);
          if (free && pend != 3'b000) begin
            w = pick(pend, last_own);
            check("grant_mem_en", 32'(bus.mem_en), 1);
            check("grant_owner", 32'(bus.gnt), 32'(3'b001 << w));
            if (bus.mem_en) begin
              check("grant_addr", 32'(bus.mem_addr), 32'(r_addr[w]));
              check("grant_we", 32'(bus.mem_we), 32'(r_we[w]));
              check("grant_wdata", 32'(bus.mem_wdata), 32'(r_wdata[w]));
              sb.push_back('{id: w, due: cyc + WS + 1, we: r_we[w], addr: r_addr[w], wdata: r_wdata[w]});
              run_addr = bus.mem_addr; run_wdata = bus.mem_wdata; run_we = bus.mem_we;
            end
          end else if (free) begin
            check("idle_mem_en", 32'(bus.mem_en), 0);
            check("idle_gnt", 32'(bus.gnt), 0);
          end else begin
            check("no_spurious_start", 32'(bus.mem_en && !prev_mem_en), 0);
          end
        end

        if (bus.mem_en && prev_mem_en) begin
          check("hold_addr", 32'(bus.mem_addr), 32'(run_addr));
          check("hold_wdata", 32'(bus.mem_wdata), 32'(run_wdata));
          check("hold_we", 32'(bus.mem_we), 32'(run_we));
        end

        // Memory device: data is only valid in the last mem_en cycle, garbage otherwise.
        if (bus.mem_en) begin
          dev_run++;
        end else if (prev_mem_en) begin
          check("mem_en_len", 32'(dev_run), 32'(WS + 1));
          dev_run = 0;
        end
        if (bus.mem_en && dev_run == WS + 1) begin
          if (bus.mem_we) mem_arr[bus.mem_addr[7:0]] = bus.mem_wdata;
          bus.mem_rdata = mem_arr[bus.mem_addr[7:0]];
        end else begin
          bus.mem_rdata = 16'($urandom);
        end

        if (bus.ack != 3'b000) begin
          if (sb.size() == 0) begin
            check("unexpected_ack", 32'(bus.ack), 0);
          end else begin
            e = sb.pop_front();
            check("ack_owner", 32'(bus.ack), 32'(3'b001 << e.id));
            check("resp_gnt", 32'(bus.gnt), 32'(3'b001 << e.id));
            check("ack_cycle", 32'(cyc), 32'(e.due));
            exp_rd = e.we ? model_rdata : ref_mem[e.addr[7:0]];
            if (e.we) ref_mem[e.addr[7:0]] = e.wdata;
            model_rdata = exp_rd;
            check("ack_rdata", 32'(bus.rdata), 32'(exp_rd));
            last_own = e.id;
            ack_own_q.push_back(e.id);
            ack_cyc_q.push_back(cyc);
          end
        end else if (sb.size() != 0 && cyc > sb[0].due) begin
          check("ack_timeout", 32'(cyc), 32'(sb[0].due));
          void'(sb.pop_front());
        end

        prev_req = bus.req; prev_ack = bus.ack; prev_gnt = bus.gnt;
        prev_mem_en = bus.mem_en; prev_ok = 1;
      end
    end
  end

  // ---------------- test sequence ----------------
  task automatic drain();
    int n = 0;
    while ((busy != 3'b000 || sb.size() != 0) && n < 300) begin
      step();
      n++;
    end
    check("drain_busy", 32'(busy), 0);
  endtask

  task automatic single(input int i, input logic we, input logic [15:0] a, input logic [15:0] d);
    int n = 0;
    raise(i, we, a, d);
    while (busy[i] && n < 50) begin
      step();
      n++;
    end
    check("single_done", 32'(busy[i]), 0);
  endtask

  initial begin
    int exp_order [4];
    int n;
`ifdef MEM_BUS_ARBITER_FIXED_PRIO_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{0, 1, 2, 0};
`endif
    busy = '0; last_ack = '0; reraise = 0; rand_en = 0; drop_en = 0;
    bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0;
    for (int i = 0; i < 3; i++) begin
      r_we[i] = 1'b0; r_addr[i] = '0; r_wdata[i] = '0;
    end

    // Reset state.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_gnt", 32'(bus.gnt), 0);
    check("rst_ack", 32'(bus.ack), 0);
    check("rst_rdata", 32'(bus.rdata), 0);
    check("rst_mem_en", 32'(bus.mem_en), 0);
    check("rst_mem_we", 32'(bus.mem_we), 0);
    check("rst_mem_addr", 32'(bus.mem_addr), 0);
    check("rst_mem_wdata", 32'(bus.mem_wdata), 0);

    // Three-way contention held from reset, requesters re-raising right after their ack.
    for (int i = 0; i < 3; i++) raise(i, 1'b0, rand_addr(), 16'($urandom));
    reraise = 1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n = 0;
    while (ack_own_q.size() < 4 && n < 100) begin
      step();
      n++;
    end
    check("contention_acks", 32'(ack_own_q.size() >= 4), 1);
    if (ack_own_q.size() >= 4) begin
      for (int k = 0; k < 4; k++) check("contention_order", 32'(ack_own_q[k]), 32'(exp_order[k]));
      for (int k = 0; k < 3; k++)
        check("contention_spacing", 32'(ack_cyc_q[k+1] - ack_cyc_q[k]), 32'(WS + 2));
    end
    reraise = 0;
    drain();

    // Directed single accesses.
    single(0, 1'b0, 16'h0040, 16'h0000);
    check("read_beef", 32'(bus.rdata), 32'h0000BEEF);
    single(1, 1'b1, 16'h0100, 16'h1234);
    check("write_keeps_rdata", 32'(bus.rdata), 32'h0000BEEF);
    single(1, 1'b0, 16'h0100, 16'h0000);
    check("read_back_1234", 32'(bus.rdata), 32'h00001234);

    // Random traffic, including requesters dropping req mid-access.
    rand_en = 1; drop_en = 1;
    repeat (3000) step();
    rand_en = 0; drop_en = 0;
    drain();

    // Reset during an access: strobes drop at once, no ack, fresh arbitration afterwards.
    raise(0, 1'b0, rand_addr(), 16'($urandom));
    n = 0;
    while (bus.gnt == 3'b000 && n < 20) begin
      step();
      n++;
    end
    check("pre_reset_grant", 32'(bus.gnt), 32'b001);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_mem_en", 32'(bus.mem_en), 0);
    check("mid_rst_gnt", 32'(bus.gnt), 0);
    check("mid_rst_ack", 32'(bus.ack), 0);
    raise(1, 1'b0, rand_addr(), 16'($urandom));
    ack_own_q.delete();
    ack_cyc_q.delete();
    step();
    step();
    rst_n = 1'b1;
    drain();
    check("post_rst_acks", 32'(ack_own_q.size()), 2);
    if (ack_own_q.size() >= 1) check("post_rst_first", 32'(ack_own_q[0]), 0);
    check("sb_empty", 32'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute backstop so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end
endmodule
